// File: rtl/shot_turn_controller_if.sv
// Purpose : groups the keyboard/ball-status inputs and the shot-control outputs
//           of shot_turn_controller into one bundle.
// Ports   : slave = controller side (consumes keys/frame/ball status, drives
//           charge/release/turn outputs); master = the environment driving it.
interface shot_turn_controller_if #(
   parameter int NUM_BALLS = 8
);
   // environment -> controller
   logic                 startOfFrame;
   logic                 keyUp;
   logic                 keyDown;
   logic                 keyLeft;
   logic                 keyRight;
   logic                 keyFire;
   logic [NUM_BALLS-1:0] ballMoving;
   logic                 whitePocketed;
   logic                 ballPocketed;
   // controller -> environment
   logic                 chargeUp;
   logic                 chargeDown;
   logic                 chargeLeft;
   logic                 chargeRight;
   logic                 releaseBall;
   logic                 currentPlayer;
   logic                 foul;
   logic                 respotWhite;
   logic signed [3:0]    xSteps;
   logic signed [3:0]    ySteps;
   logic [2:0]           shotState;

   modport master (
      output startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyFire,
             ballMoving, whitePocketed, ballPocketed,
      input  chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
             currentPlayer, foul, respotWhite, xSteps, ySteps, shotState
   );

   modport slave (
      input  startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyFire,
             ballMoving, whitePocketed, ballPocketed,
      output chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
             currentPlayer, foul, respotWhite, xSteps, ySteps, shotState
   );
endinterface

// File: rtl/shot_turn_controller.sv
// Purpose : cue-ball shot sequencer: rate-limited charge pulses from held keys,
//           one release pulse per shot, waits for all balls to settle, then
//           resolves the turn (player switch, foul, white re-spot).
// Latency : every pulse output is registered and appears one clk after its cause.
// Flow    : no backpressure; inputs are levels/pulses sampled every clk.
// Ports   : clk, resetN (async, active-low) plain; everything else via
//           shot_turn_controller_if.slave.
module shot_turn_controller #(
   parameter int NUM_BALLS            = 8,
   parameter int CHARGE_PERIOD_FRAMES = 4,
   parameter int MAX_CHARGE_STEPS     = 5,
   parameter int SETTLE_FRAMES        = 16
) (
   input  logic                    clk,
   input  logic                    resetN,
   shot_turn_controller_if.slave   sif
);

   localparam logic [2:0] ST_AIM      = 3'd0;
   localparam logic [2:0] ST_CHARGE   = 3'd1;
   localparam logic [2:0] ST_RELEASE  = 3'd2;
   localparam logic [2:0] ST_ROLLING  = 3'd3;
   localparam logic [2:0] ST_SETTLE   = 3'd4;
   localparam logic [2:0] ST_TURN_END = 3'd5;

   localparam int FCW = (CHARGE_PERIOD_FRAMES > 1) ? $clog2(CHARGE_PERIOD_FRAMES) : 1;
   // Settle counter must hold SETTLE_FRAMES itself without wrapping.
   localparam int SCW = $clog2(SETTLE_FRAMES + 1);

   localparam logic [FCW-1:0]    FC_LAST  = FCW'(CHARGE_PERIOD_FRAMES - 1);
   localparam logic [SCW-1:0]    SC_DONE  = SCW'(SETTLE_FRAMES);
   localparam logic signed [3:0] STEP_MAX = 4'(MAX_CHARGE_STEPS);
   localparam logic signed [3:0] STEP_MIN = -STEP_MAX;

   logic [2:0]        state_q, state_d;
   logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
   logic [SCW-1:0]    settle_cnt_q, settle_cnt_d;
   logic signed [3:0] x_steps_q, x_steps_d;
   logic signed [3:0] y_steps_q, y_steps_d;
   logic              fire_prev_q, fire_prev_d;
   logic              white_lat_q, white_lat_d;
   logic              ball_lat_q, ball_lat_d;
   logic              player_q, player_d;
   logic              foul_q, foul_d;
   logic              respot_q, respot_d;
   logic              release_q, release_d;
   logic              chg_up_q, chg_up_d;
   logic              chg_dn_q, chg_dn_d;
   logic              chg_lf_q, chg_lf_d;
   logic              chg_rt_q, chg_rt_d;

   logic [NUM_BALLS-1:0] moving;
   logic                 moving_any;
   logic                 fire_edge;
   logic                 charge_tick;
   logic [SCW-1:0]       settle_inc;

   assign moving      = sif.ballMoving;
   assign moving_any  = |moving;
   assign fire_edge   = sif.keyFire & ~fire_prev_q;
   assign charge_tick = sif.startOfFrame & (frame_cnt_q == FC_LAST);
   assign settle_inc  = settle_cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      frame_cnt_d  = frame_cnt_q;
      settle_cnt_d = settle_cnt_q;
      x_steps_d    = x_steps_q;
      y_steps_d    = y_steps_q;
      fire_prev_d  = sif.keyFire;
      white_lat_d  = white_lat_q;
      ball_lat_d   = ball_lat_q;
      player_d     = player_q;
      foul_d       = foul_q;
      respot_d     = 1'b0;
      release_d    = 1'b0;
      chg_up_d     = 1'b0;
      chg_dn_d     = 1'b0;
      chg_lf_d     = 1'b0;
      chg_rt_d     = 1'b0;

      case (state_q)
         ST_AIM, ST_CHARGE: begin
            if (sif.startOfFrame)
               frame_cnt_d = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + 1'b1;
            // Opposing keys cancel; saturated axes stay silent.
            if (charge_tick) begin
               chg_up_d = sif.keyUp    & ~sif.keyDown  & (y_steps_q < STEP_MAX);
               chg_dn_d = sif.keyDown  & ~sif.keyUp    & (y_steps_q > STEP_MIN);
               chg_rt_d = sif.keyRight & ~sif.keyLeft  & (x_steps_q < STEP_MAX);
               chg_lf_d = sif.keyLeft  & ~sif.keyRight & (x_steps_q > STEP_MIN);
            end
            if (chg_up_d)      y_steps_d = y_steps_q + 4'sd1;
            else if (chg_dn_d) y_steps_d = y_steps_q - 4'sd1;
            if (chg_rt_d)      x_steps_d = x_steps_q + 4'sd1;
            else if (chg_lf_d) x_steps_d = x_steps_q - 4'sd1;

            if ((state_q == ST_AIM) && (chg_up_d | chg_dn_d | chg_lf_d | chg_rt_d))
               state_d = ST_CHARGE;
            // Release decision sees the charge applied in this same cycle.
            if ((state_q == ST_CHARGE) && fire_edge && !moving_any &&
                ((x_steps_d != 4'sd0) || (y_steps_d != 4'sd0)))
               state_d = ST_RELEASE;
         end

         ST_RELEASE: begin
            release_d    = 1'b1;
            foul_d       = 1'b0;
            white_lat_d  = 1'b0;
            ball_lat_d   = 1'b0;
            x_steps_d    = 4'sd0;
            y_steps_d    = 4'sd0;
            settle_cnt_d = '0;
            state_d      = ST_ROLLING;
         end

         ST_ROLLING: begin
            white_lat_d = white_lat_q | sif.whitePocketed;
            ball_lat_d  = ball_lat_q  | sif.ballPocketed;
            // Settle counter doubles as the stuck-shot guard while rolling.
            if (sif.startOfFrame) begin
               if (moving_any || (settle_inc == SC_DONE)) begin
                  state_d      = ST_SETTLE;
                  settle_cnt_d = '0;
               end else begin
                  settle_cnt_d = settle_inc;
               end
            end
         end

         ST_SETTLE: begin
            white_lat_d = white_lat_q | sif.whitePocketed;
            ball_lat_d  = ball_lat_q  | sif.ballPocketed;
            if (sif.startOfFrame) begin
               if (moving_any) begin
                  settle_cnt_d = '0;
               end else begin
                  settle_cnt_d = settle_inc;
                  if (settle_inc == SC_DONE)
                     state_d = ST_TURN_END;
               end
            end
         end

         ST_TURN_END: begin
            if (white_lat_q) begin
               foul_d   = 1'b1;
               respot_d = 1'b1;
               player_d = ~player_q;
            end else if (!ball_lat_q) begin
               player_d = ~player_q;
            end
            state_d     = ST_AIM;
            frame_cnt_d = '0;
         end

         default: begin
            state_d     = ST_AIM;
            frame_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= ST_AIM;
         frame_cnt_q  <= '0;
         settle_cnt_q <= '0;
         x_steps_q    <= 4'sd0;
         y_steps_q    <= 4'sd0;
         fire_prev_q  <= 1'b0;
         white_lat_q  <= 1'b0;
         ball_lat_q   <= 1'b0;
         player_q     <= 1'b0;
         foul_q       <= 1'b0;
         respot_q     <= 1'b0;
         release_q    <= 1'b0;
         chg_up_q     <= 1'b0;
         chg_dn_q     <= 1'b0;
         chg_lf_q     <= 1'b0;
         chg_rt_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         x_steps_q    <= x_steps_d;
         y_steps_q    <= y_steps_d;
         fire_prev_q  <= fire_prev_d;
         white_lat_q  <= white_lat_d;
         ball_lat_q   <= ball_lat_d;
         player_q     <= player_d;
         foul_q       <= foul_d;
         respot_q     <= respot_d;
         release_q    <= release_d;
         chg_up_q     <= chg_up_d;
         chg_dn_q     <= chg_dn_d;
         chg_lf_q     <= chg_lf_d;
         chg_rt_q     <= chg_rt_d;
      end
   end

   assign sif.chargeUp      = chg_up_q;
   assign sif.chargeDown    = chg_dn_q;
   assign sif.chargeLeft    = chg_lf_q;
   assign sif.chargeRight   = chg_rt_q;
   assign sif.releaseBall   = release_q;
   assign sif.currentPlayer = player_q;
   assign sif.foul          = foul_q;
   assign sif.respotWhite   = respot_q;
   assign sif.xSteps        = x_steps_q;
   assign sif.ySteps        = y_steps_q;
   assign sif.shotState     = state_q;

endmodule

// File: tb/tb_shot_turn_controller.sv
// Purpose : directed-vector bench for shot_turn_controller with a per-cycle
//           behavioural model plus literal expectations per scenario.
// Ports   : none (top-level bench).
module tb_shot_turn_controller;

   localparam int NB   = 8;
   localparam int CP   = 4;
   localparam int MAXS = 5;
   localparam int SF   = 16;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   shot_turn_controller_if #(.NUM_BALLS(NB)) sif();

   shot_turn_controller #(
      .NUM_BALLS(NB), .CHARGE_PERIOD_FRAMES(CP),
      .MAX_CHARGE_STEPS(MAXS), .SETTLE_FRAMES(SF)
   ) dut (
      .clk(clk), .resetN(resetN), .sif(sif)
   );

   int vectors = 0, miscompares = 0;
   int frame_no = 0, te_frame = -1;
   int n_up = 0, n_dn = 0, n_lf = 0, n_rt = 0, n_rel = 0, n_resp = 0;

   // ---------------- behavioural model ----------------
   // phase: 0 aim, 1 charge, 2 release, 3 rolling, 4 settle, 5 turn end
   int phase, frames_in_aim, xs, ys, idle_frames, still_frames, player;
   bit m_foul, m_white, m_ball, fire_seen;
   bit e_up, e_dn, e_lf, e_rt, e_rel, e_resp;
   bit sof_s, mv_s, fe_s, any_pulse;
   int ph0;

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         phase = 0; frames_in_aim = 0; xs = 0; ys = 0;
         idle_frames = 0; still_frames = 0; player = 0;
         m_foul = 0; m_white = 0; m_ball = 0; fire_seen = 0;
         {e_up, e_dn, e_lf, e_rt, e_rel, e_resp} = '0;
      end else begin
         sof_s = sif.startOfFrame;
         mv_s  = (sif.ballMoving != '0);
         fe_s  = sif.keyFire && !fire_seen;
         fire_seen = sif.keyFire;
         {e_up, e_dn, e_lf, e_rt, e_rel, e_resp} = '0;
         ph0 = phase;
         if (ph0 == 0 || ph0 == 1) begin
            if (sof_s) begin
               if ((frames_in_aim % CP) == CP - 1) begin
                  if (sif.keyUp && !sif.keyDown && ys < MAXS)     begin e_up = 1; ys++; end
                  if (sif.keyDown && !sif.keyUp && ys > -MAXS)    begin e_dn = 1; ys--; end
                  if (sif.keyRight && !sif.keyLeft && xs < MAXS)  begin e_rt = 1; xs++; end
                  if (sif.keyLeft && !sif.keyRight && xs > -MAXS) begin e_lf = 1; xs--; end
               end
               frames_in_aim++;
            end
            any_pulse = e_up | e_dn | e_lf | e_rt;
            if (ph0 == 0 && any_pulse) phase = 1;
            if (ph0 == 1 && fe_s && (xs != 0 || ys != 0) && !mv_s) phase = 2;
         end else if (ph0 == 2) begin
            e_rel = 1; m_foul = 0; m_white = 0; m_ball = 0;
            xs = 0; ys = 0; idle_frames = 0; phase = 3;
         end else if (ph0 == 3 || ph0 == 4) begin
            if (sif.whitePocketed) m_white = 1;
            if (sif.ballPocketed)  m_ball  = 1;
            if (sof_s && ph0 == 3) begin
               idle_frames++;
               if (mv_s || idle_frames == SF) begin phase = 4; still_frames = 0; end
            end else if (sof_s) begin
               still_frames = mv_s ? 0 : still_frames + 1;
               if (still_frames == SF) phase = 5;
            end
         end else begin
            if (m_white) begin m_foul = 1; e_resp = 1; player = 1 - player; end
            else if (!m_ball) player = 1 - player;
            phase = 0; frames_in_aim = 0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic compare_outputs();
      logic [18:0] act, exp;
      act = {sif.chargeUp, sif.chargeDown, sif.chargeLeft, sif.chargeRight,
             sif.releaseBall, sif.respotWhite, sif.foul, sif.currentPlayer,
             sif.shotState, sif.xSteps, sif.ySteps};
      exp = {e_up, e_dn, e_lf, e_rt, e_rel, e_resp, m_foul, player[0],
             phase[2:0], xs[3:0], ys[3:0]};
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL cycle_outputs @%0t: got %h expected %h (up,dn,lf,rt,rel,resp,foul,pl,st[3],x[4],y[4])",
                  $time, act, exp);
      end
      n_up   += int'(sif.chargeUp);
      n_dn   += int'(sif.chargeDown);
      n_lf   += int'(sif.chargeLeft);
      n_rt   += int'(sif.chargeRight);
      n_rel  += int'(sif.releaseBall);
      n_resp += int'(sif.respotWhite);
      if (sif.shotState == 3'd5) te_frame = frame_no;
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      #2;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         sif.startOfFrame = 1'b1;
         frame_no++;
         step();
         sif.startOfFrame = 1'b0;
         for (int k = 0; k < 3; k++) step();
      end
   endtask

   task automatic fire();
      sif.keyFire = 1'b1; step(); step();
      sif.keyFire = 1'b0; step(); step();
   endtask

   int b0, b1;

   initial begin
      resetN = 1'b0;
      sif.startOfFrame = 0; sif.keyUp = 0; sif.keyDown = 0; sif.keyLeft = 0;
      sif.keyRight = 0; sif.keyFire = 0; sif.ballMoving = '0;
      sif.whitePocketed = 0; sif.ballPocketed = 0;
      step(); step();
      check("reset_state", int'(sif.shotState), 0);
      check("reset_player", int'(sif.currentPlayer), 0);
      check("reset_ysteps", int'(sif.ySteps), 0);
      resetN = 1'b1;
      step();

      // keyUp held 30 frames: five pulses then saturation
      b0 = n_up;
      sif.keyUp = 1; frames(30); sif.keyUp = 0;
      check("up_pulse_count", n_up - b0, 5);
      check("up_ysteps_sat", int'(sif.ySteps), 5);
      check("up_state_charge", int'(sif.shotState), 1);

      // left+right cancel, fire ignored in AIM
      resetN = 1'b0; step(); resetN = 1'b1; step();
      b0 = n_lf + n_rt; b1 = n_rel;
      sif.keyLeft = 1; sif.keyRight = 1; frames(12); sif.keyLeft = 0; sif.keyRight = 0;
      fire();
      check("lr_no_pulses", n_lf + n_rt - b0, 0);
      check("lr_xsteps", int'(sif.xSteps), 0);
      check("lr_state_aim", int'(sif.shotState), 0);
      check("lr_no_release", n_rel - b1, 0);

      // ySteps=2 then fire
      sif.keyUp = 1; frames(8); sif.keyUp = 0;
      check("y2_ysteps", int'(sif.ySteps), 2);
      b1 = n_rel;
      fire();
      check("y2_release_count", n_rel - b1, 1);
      check("y2_ysteps_cleared", int'(sif.ySteps), 0);
      check("y2_state_rolling", int'(sif.shotState), 3);

      // 20 moving frames then still: TURN_END after 16 still frames
      sif.ballMoving = 8'h01; frames(20);
      b0 = frame_no; te_frame = -1; b1 = n_resp;
      sif.ballMoving = '0; frames(20);
      check("settle_frame_count", te_frame - b0, SF);
      check("turn1_player", int'(sif.currentPlayer), 1);
      check("turn1_foul", int'(sif.foul), 0);
      check("turn1_no_respot", n_resp - b1, 0);

      // white pocketed during SETTLE
      sif.keyDown = 1; frames(8); sif.keyDown = 0;
      fire();
      b1 = n_resp;
      sif.ballMoving = 8'h80; frames(2);
      sif.whitePocketed = 1; step(); sif.whitePocketed = 0;
      sif.ballMoving = '0; frames(20);
      check("white_respot_count", n_resp - b1, 1);
      check("white_foul", int'(sif.foul), 1);
      check("white_player", int'(sif.currentPlayer), 0);
      sif.keyRight = 1; frames(8); sif.keyRight = 0;
      fire();
      check("white_foul_cleared", int'(sif.foul), 0);
      check("white_next_rolling", int'(sif.shotState), 3);
      sif.ballMoving = 8'h02; frames(1); sif.ballMoving = '0; frames(18);
      check("turn3_player", int'(sif.currentPlayer), 1);

      // reset mid-SETTLE with an object ball latched
      sif.keyUp = 1; frames(8); sif.keyUp = 0;
      fire();
      sif.ballMoving = 8'h04; frames(1);
      sif.ballPocketed = 1; step(); sif.ballPocketed = 0;
      frames(2);
      check("pre_reset_settle", int'(sif.shotState), 4);
      resetN = 1'b0; step();
      check("rst_state", int'(sif.shotState), 0);
      check("rst_player", int'(sif.currentPlayer), 0);
      check("rst_foul", int'(sif.foul), 0);
      check("rst_ysteps", int'(sif.ySteps), 0);
      resetN = 1'b1; sif.ballMoving = '0;
      b1 = n_resp;
      frames(20);
      check("post_rst_state", int'(sif.shotState), 0);
      check("post_rst_player", int'(sif.currentPlayer), 0);
      check("post_rst_no_respot", n_resp - b1, 0);

      // negative saturation on X
      b0 = n_lf;
      sif.keyLeft = 1; frames(30); sif.keyLeft = 0;
      check("left_pulse_count", n_lf - b0, 5);
      check("left_xsteps_sat", int'(sif.xSteps), -5);
      check("left_state_charge", int'(sif.shotState), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
